// File: rtl/conv_line_sched.sv
// conv_line_sched: write scheduler and pass sequencer for four rotating 3x3-conv line-buffer banks.
module conv_line_sched #(
    parameter logic [10:0] IMAGE_WIDTH  = 11'd28,
    parameter logic [10:0] IMAGE_HEIGHT = 11'd28,
    parameter int          ADDR_W       = 11
) (
    input  logic              clk,
    input  logic              RESET_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              wr_en0,
    output logic              wr_en1,
    output logic              wr_en2,
    output logic              wr_en3,
    output logic              start_rd,
    input  logic              fin_rd,
    output logic              frame_done,
    output logic              busy,
    output logic              underrun_err
);
    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;
    localparam logic [11:0] ROWS = 12'(IMAGE_HEIGHT);
    localparam logic [11:0] PASSES = ROWS - 12'd2;
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMAGE_WIDTH - 11'd1);
    state_t state, state_nx;
    logic [ADDR_W-1:0] col;
    logic [11:0] wr_row, rows_loaded, passes_done, rows_nx, passes_nx, credit;
    logic [3:0] wr_en;
    logic accept, commit_last, fin, start;
    assign credit      = wr_row - passes_done;
    assign pix_ready   = (state == FILL || state == RUN) && wr_row < ROWS && credit < 12'd4;
    assign accept      = pix_valid && pix_ready;
    assign commit_last = (|wr_en) && wr_addr == LAST_COL;
    assign fin         = fin_rd && (state == RUN || state == FLUSH);
    assign start       = state == IDLE && frame_start;
    // transitions look at the post-update counts so start_rd rises right after row 2 commits
    assign rows_nx     = rows_loaded + {11'd0, commit_last};
    assign passes_nx   = passes_done + {11'd0, fin};
    assign {wr_en3, wr_en2, wr_en1, wr_en0} = wr_en;
    assign start_rd    = state == RUN || state == FLUSH;
    assign frame_done  = state == DONE;
    assign busy        = state != IDLE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = frame_start ? FILL : IDLE;
            FILL:    state_nx = rows_nx == 12'd3 ? RUN : FILL;
            RUN:     state_nx = passes_nx == PASSES ? DONE : rows_nx == ROWS ? FLUSH : RUN;
            FLUSH:   state_nx = passes_nx == PASSES ? DONE : FLUSH;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= IDLE;
            col          <= '0;
            wr_row       <= '0;
            rows_loaded  <= '0;
            passes_done  <= '0;
            wr_en        <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            underrun_err <= 1'b0;
        end else begin
            state <= state_nx;
            wr_en <= accept ? 4'b1 << wr_row[1:0] : 4'b0;
            if (accept) begin
                wr_addr <= col;
                wr_data <= pix_data;
            end
            if (start) begin
                col          <= '0;
                wr_row       <= '0;
                rows_loaded  <= '0;
                passes_done  <= '0;
                underrun_err <= 1'b0;
            end else begin
                if (accept) begin
                    col    <= col == LAST_COL ? '0 : col + 1'b1;
                    wr_row <= wr_row + {11'd0, col == LAST_COL};
                end
                rows_loaded <= rows_nx;
                passes_done <= passes_nx;
                if (fin && passes_done < PASSES - 12'd1 && rows_loaded < passes_done + 12'd4)
                    underrun_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_conv_line_sched.sv
// tb_conv_line_sched: directed plus randomized frames checked against a row/pass counting model.
module tb_conv_line_sched;
    localparam int W = 4, H = 6, P = H - 2;
    logic clk = 0, RESET_n = 1, frame_start = 0, pix_valid = 0, fin_rd = 0;
    logic [23:0] pix_data = '0;
    logic pix_ready, wr_en0, wr_en1, wr_en2, wr_en3, start_rd, frame_done, busy, underrun_err;
    logic [10:0] wr_addr;
    logic [23:0] wr_data;
    int checks = 0, errors = 0;
    int en_cnt [4];
    bit seen_done;
    bit m_active, m_done, m_err, m_pend;
    int m_beats, m_loaded, m_passes, m_bank, m_addr;
    logic [23:0] m_data;

    conv_line_sched #(.IMAGE_WIDTH(11'd4), .IMAGE_HEIGHT(11'd6), .ADDR_W(11)) dut (
        .clk(clk), .RESET_n(RESET_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_en2(wr_en2), .wr_en3(wr_en3),
        .start_rd(start_rd), .fin_rd(fin_rd), .frame_done(frame_done), .busy(busy),
        .underrun_err(underrun_err)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return m_active && !m_done && m_beats / W < H && m_beats / W - m_passes < 4;
    endfunction

    function automatic bit m_rd();
        return m_active && !m_done && m_loaded >= 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_err = 0; m_pend = 0;
        m_beats = 0; m_loaded = 0; m_passes = 0;
    endtask

    task automatic check_zero(input string tag);
        chk(tag, 32'({pix_ready, wr_en3, wr_en2, wr_en1, wr_en0, start_rd, frame_done, busy, underrun_err}), 32'd0);
        chk({tag, "_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_data"}, 32'(wr_data), 32'd0);
    endtask

    task automatic check_all();
        chk("pix_ready", 32'(pix_ready), 32'(m_ready()));
        chk("busy", 32'(busy), 32'(m_active));
        chk("start_rd", 32'(start_rd), 32'(m_rd()));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("underrun_err", 32'(underrun_err), 32'(m_err));
        chk("wr_en", 32'({wr_en3, wr_en2, wr_en1, wr_en0}), m_pend ? 32'(1) << m_bank : 32'd0);
        if (m_pend) begin
            chk("wr_addr", 32'(wr_addr), 32'(m_addr));
            chk("wr_data", 32'(wr_data), 32'(m_data));
        end
    endtask

    task automatic cycle(input bit fs, input bit pv, input bit fr);
        bit rdy, rd, acc, fin, commit;
        logic [23:0] d;
        d = 24'($urandom);
        frame_start = fs; pix_valid = pv; pix_data = d; fin_rd = fr;
        rdy = m_ready();
        rd = m_rd();
        @(posedge clk);
        acc = pv && rdy;
        fin = fr && rd;
        commit = m_pend && m_addr == W - 1;
        if (m_done) begin
            m_active = 0;
            m_done = 0;
        end else if (!m_active) begin
            if (fs) begin
                m_active = 1; m_beats = 0; m_loaded = 0; m_passes = 0; m_err = 0;
            end
        end else begin
            if (fin) begin
                if (m_passes < P - 1 && m_loaded < m_passes + 4) m_err = 1;
                m_passes++;
                m_done = m_passes == P;
            end
            if (commit) m_loaded++;
        end
        m_pend = acc;
        if (acc) begin
            m_bank = (m_beats / W) % 4;
            m_addr = m_beats % W;
            m_data = d;
            m_beats++;
        end
        #1;
        check_all();
        if (frame_done) seen_done = 1;
        if (wr_en0) en_cnt[0]++;
        if (wr_en1) en_cnt[1]++;
        if (wr_en2) en_cnt[2]++;
        if (wr_en3) en_cnt[3]++;
        @(negedge clk);
    endtask

    // safe: only finish a pass once every row it (and the credit) needs is resident
    task automatic run_frame(input bit safe);
        int n;
        bit fr, prev;
        n = 0; prev = 0; seen_done = 0;
        while (!seen_done && n < 300) begin
            fr = 0;
            if (m_rd() && !prev && $urandom_range(0, safe ? 1 : 5) == 0)
                fr = !safe || m_loaded >= m_passes + (m_passes < P - 1 ? 4 : 3);
            prev = fr;
            cycle(0, $urandom_range(0, 3) != 0, fr);
            n++;
        end
        chk("frame_done_seen", 32'(seen_done), 32'd1);
    endtask

    initial begin
        en_cnt = '{default: 0};
        #2 RESET_n = 0;
        #1;
        model_reset();
        check_zero("reset_async");
        repeat (2) @(negedge clk);
        check_zero("reset_hold");
        RESET_n = 1;
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(pix_ready), 32'd1);
        repeat (12) cycle(0, 1, 0);
        chk("fill_rd_early", 32'(start_rd), 32'd0);
        cycle(0, 1, 0);
        chk("fill_rd_rise", 32'(start_rd), 32'd1);
        chk("fill_bank_counts", 32'({8'(en_cnt[0]), 8'(en_cnt[1]), 8'(en_cnt[2])}), 32'h040404);
        repeat (3) cycle(0, 1, 0);
        chk("row3_bank3", 32'(en_cnt[3]), 32'd4);
        repeat (3) cycle(0, 1, 0);
        chk("credit_stall", 32'(pix_ready), 32'd0);
        cycle(0, 1, 1);
        chk("credit_freed", 32'(pix_ready), 32'd1);
        cycle(0, 1, 0);
        chk("row4_bank0", 32'({wr_en3, wr_en2, wr_en1, wr_en0}), 32'd1);
        chk("row4_addr", 32'(wr_addr), 32'd0);
        run_frame(1);
        cycle(1, 0, 0);
        chk("done_start_ignored", 32'(busy), 32'd0);
        cycle(0, 0, 0);
        chk("idle_after_done", 32'(busy), 32'd0);

        cycle(1, 0, 0);
        repeat (12) cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        chk("underrun_set", 32'(underrun_err), 32'd1);
        cycle(0, 0, 0);
        run_frame(0);
        cycle(0, 0, 0);
        chk("underrun_sticky", 32'(underrun_err), 32'd1);
        cycle(1, 0, 0);
        chk("underrun_cleared", 32'(underrun_err), 32'd0);
        run_frame(1);
        cycle(0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) cycle(0, 0, 0);
            cycle(1, 0, 0);
            run_frame(i % 2 == 0);
            cycle(0, 0, 0);
        end

        cycle(1, 0, 0);
        repeat (14) cycle(0, 1, 0);
        #2 RESET_n = 0;
        #1;
        model_reset();
        check_zero("midframe_reset");
        @(negedge clk);
        RESET_n = 1;
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        chk("restart_bank0", 32'({wr_en3, wr_en2, wr_en1, wr_en0}), 32'd1);
        chk("restart_addr", 32'(wr_addr), 32'd0);
        run_frame(1);
        cycle(0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
